// File: rtl/baseline_a55_fabric.sv
// Fabric control block for the Agilex5 A55 baseline design.
// Releases the fabric reset a fixed number of cycles after system reset,
// and exposes LEDs, debounced switches/buttons, edge captures and a
// button interrupt to the HPS through a small 8-word register slave.
module baseline_a55_fabric #(
    parameter int          RESET_HOLD_CYCLES = 16,
    parameter int          DEBOUNCE_CYCLES   = 1000,
    parameter int          SYNC_STAGES       = 2,
    parameter logic [3:0]  LED_RESET         = 4'h0,
    parameter logic [31:0] ID_VALUE          = 32'hA55B_0001
) (
    input  logic        pll_refclk_100,
    input  logic        system_reset,
    output logic        sys_clk_100_reset_n,
    input  logic [3:0]  fpga_user_switches,
    input  logic [3:0]  fpga_user_push_buttons,
    output logic [3:0]  fpga_user_leds,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NIN    = 8;

    logic [HOLD_W-1:0] r_holdCount;
    logic              r_resetN;

    logic [NIN-1:0]    r_sync [SYNC_STAGES];
    logic [NIN-1:0]    r_debounced;
    logic [CNT_W-1:0]  r_dbCount [NIN];

    logic [3:0]        r_led;
    logic [3:0]        r_btnMask;
    logic [3:0]        r_btnEdge;
    logic [3:0]        r_swEdge;
    logic [31:0]       r_scratch;
    logic [31:0]       r_readData;
    logic              r_irq;

    logic [NIN-1:0]    w_rawIn;
    logic [NIN-1:0]    w_synced;
    logic [NIN-1:0]    w_debNext;
    logic [CNT_W-1:0]  w_cntNext [NIN];
    logic [NIN-1:0]    w_debChange;
    logic              w_wrEn;
    logic [3:0]        w_btnClr;
    logic [3:0]        w_swClr;
    logic [31:0]       w_readMux;

    // Buttons occupy the upper nibble, switches the lower nibble.
    assign w_rawIn     = {fpga_user_push_buttons, fpga_user_switches};
    assign w_synced    = r_sync[SYNC_STAGES-1];
    assign w_debChange = w_debNext ^ r_debounced;

    // The bus is dead until the fabric reset has been released.
    assign w_wrEn   = avs_write & r_resetN;
    assign w_btnClr = (w_wrEn && avs_address == 3'd4) ? avs_writedata[3:0] : 4'h0;
    assign w_swClr  = (w_wrEn && avs_address == 3'd5) ? avs_writedata[3:0] : 4'h0;

    assign sys_clk_100_reset_n = r_resetN;
    assign fpga_user_leds      = r_led;
    assign avs_readdata        = r_readData;
    assign irq                 = r_irq;

    // Hold the fabric reset low for RESET_HOLD_CYCLES clocks after system_reset drops.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            r_holdCount <= '0;
            r_resetN    <= 1'b0;
        end else if (!r_resetN) begin
            if (r_holdCount == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
                r_resetN <= 1'b1;
            end else begin
                r_holdCount <= r_holdCount + HOLD_W'(1);
            end
        end
    end

    // Synchroniser chain bringing the asynchronous switches and buttons into the clock domain.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_rawIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Per-bit debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
    always_comb begin
        w_debNext = r_debounced;
        for (int i = 0; i < NIN; i++) begin
            w_cntNext[i] = '0;
            if (w_synced[i] != r_debounced[i]) begin
                if (r_dbCount[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_debNext[i] = w_synced[i];
                end else begin
                    w_cntNext[i] = r_dbCount[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register the debounced levels and their counters.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            r_debounced <= '0;
            for (int i = 0; i < NIN; i++) begin
                r_dbCount[i] <= '0;
            end
        end else begin
            r_debounced <= w_debNext;
            for (int i = 0; i < NIN; i++) begin
                r_dbCount[i] <= w_cntNext[i];
            end
        end
    end

    // Edge capture with write-1-to-clear; a new edge beats a clear on the same cycle.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            r_swEdge  <= 4'h0;
            r_btnEdge <= 4'h0;
        end else begin
            r_swEdge  <= (r_swEdge  & ~w_swClr)  | w_debChange[3:0];
            r_btnEdge <= (r_btnEdge & ~w_btnClr) | w_debChange[7:4];
        end
    end

    // Writable registers: LED, button mask and scratch.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            r_led     <= LED_RESET;
            r_btnMask <= 4'h0;
            r_scratch <= 32'h0;
        end else if (w_wrEn) begin
            case (avs_address)
                3'd0:    r_led     <= avs_writedata[3:0];
                3'd3:    r_btnMask <= avs_writedata[3:0];
                3'd7:    r_scratch <= avs_writedata;
                default: ;
            endcase
        end
    end

    // Read multiplexer; it sees pre-write values so a same-cycle write is not visible yet.
    always_comb begin
        w_readMux = 32'h0;
        case (avs_address)
            3'd0:    w_readMux = {28'h0, r_led};
            3'd1:    w_readMux = {28'h0, r_debounced[3:0]};
            3'd2:    w_readMux = {28'h0, r_debounced[7:4]};
            3'd3:    w_readMux = {28'h0, r_btnMask};
            3'd4:    w_readMux = {28'h0, r_btnEdge};
            3'd5:    w_readMux = {28'h0, r_swEdge};
            3'd6:    w_readMux = ID_VALUE;
            default: w_readMux = r_scratch;
        endcase
    end

    // Read data is captured one cycle after the strobe and held between reads.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            r_readData <= 32'h0;
        end else if (avs_read) begin
            r_readData <= r_resetN ? w_readMux : 32'h0;
        end
    end

    // Level interrupt from any unmasked button capture, registered.
    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_btnEdge & r_btnMask);
        end
    end

endmodule

// File: tb/tb_baseline_a55_fabric.sv
// Testbench for baseline_a55_fabric: directed scenarios followed by
// randomised input episodes and bus traffic, compared with a register-level model.
module tb_baseline_a55_fabric;

   logic        clock;
   logic        systemReset;
   logic        resetN;
   logic [3:0]  switches;
   logic [3:0]  buttons;
   logic [3:0]  leds;
   logic [2:0]  avsAddress;
   logic        avsRead;
   logic        avsWrite;
   logic [31:0] avsWriteData;
   logic [31:0] avsReadData;
   logic        irqOut;

   int errors = 0;
   int checks = 0;

   // Behavioural model of the register file as software sees it.
   logic [3:0]  mLed, mMask, mSw, mBtn, mSwCap, mBtnCap;
   logic [31:0] mScratch;

   baseline_a55_fabric dut (
      .pll_refclk_100         (clock),
      .system_reset           (systemReset),
      .sys_clk_100_reset_n    (resetN),
      .fpga_user_switches     (switches),
      .fpga_user_push_buttons (buttons),
      .fpga_user_leds         (leds),
      .avs_address            (avsAddress),
      .avs_read               (avsRead),
      .avs_write              (avsWrite),
      .avs_writedata          (avsWriteData),
      .avs_readdata           (avsReadData),
      .irq                    (irqOut)
   );

   // 100 MHz reference clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Guard against a hung run.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [2:0] addr);
      case (addr)
         3'd0:    return {28'h0, mLed};
         3'd1:    return {28'h0, mSw};
         3'd2:    return {28'h0, mBtn};
         3'd3:    return {28'h0, mMask};
         3'd4:    return {28'h0, mBtnCap};
         3'd5:    return {28'h0, mSwCap};
         3'd6:    return 32'hA55B_0001;
         default: return mScratch;
      endcase
   endfunction

   task automatic modelWrite(input logic [2:0] addr, input logic [31:0] data);
      case (addr)
         3'd0:    mLed = data[3:0];
         3'd3:    mMask = data[3:0];
         3'd4:    mBtnCap = mBtnCap & ~data[3:0];
         3'd5:    mSwCap = mSwCap & ~data[3:0];
         3'd7:    mScratch = data;
         default: ;
      endcase
   endtask

   function automatic logic modelIrq();
      return |(mBtnCap & mMask);
   endfunction

   task automatic modelReset();
      mLed = 4'h0; mMask = 4'h0; mSw = 4'h0; mBtn = 4'h0;
      mSwCap = 4'h0; mBtnCap = 4'h0; mScratch = 32'h0;
   endtask

   task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
      avsAddress = addr;
      avsWriteData = data;
      avsWrite = 1'b1;
      tick(1);
      avsWrite = 1'b0;
   endtask

   task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
      avsAddress = addr;
      avsRead = 1'b1;
      tick(1);
      avsRead = 1'b0;
      data = avsReadData;
   endtask

   task automatic readCheck(input string tag, input logic [2:0] addr);
      logic [31:0] rd;
      busRead(addr, rd);
      checkOutput(tag, rd, modelRead(addr));
   endtask

   // Drive new input levels and hold them long enough to be accepted.
   task automatic applyStimulus(input logic [3:0] sw, input logic [3:0] btn, input int hold);
      switches = sw;
      buttons = btn;
      tick(hold);
      mSwCap  = mSwCap | (mSw ^ sw);
      mBtnCap = mBtnCap | (mBtn ^ btn);
      mSw  = sw;
      mBtn = btn;
   endtask

   // Drive a short excursion that must be rejected, then return to the accepted levels.
   task automatic applyGlitch(input logic [3:0] sw, input logic [3:0] btn, input int len);
      switches = sw;
      buttons = btn;
      tick(len);
      switches = mSw;
      buttons = mBtn;
      tick(50);
   endtask

   // Wait for the fabric reset release and return the number of clocks it took.
   task automatic waitRelease(output int cyc);
      cyc = 0;
      while (resetN !== 1'b1 && cyc <= 1000) begin
         tick(1);
         cyc++;
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] rd;
      logic [31:0] data;
      logic [2:0]  addr;
      logic [3:0]  nSw, nBtn;
      int          kind;

      systemReset = 1'b1;
      switches = 4'h0;
      buttons = 4'h0;
      avsAddress = 3'd0;
      avsRead = 1'b0;
      avsWrite = 1'b0;
      avsWriteData = 32'h0;
      modelReset();

      // Reset pulse and release timing.
      tick(5);
      checkOutput("rst_resetn_low", resetN, 1'b0);
      checkOutput("rst_leds", leds, 4'h0);
      checkOutput("rst_irq", irqOut, 1'b0);
      checkOutput("rst_readdata", avsReadData, 32'h0);
      systemReset = 1'b0;
      waitRelease(cyc);
      checkOutput("release_cycles", cyc, 16);

      // ID, idle outputs, scratch.
      checkOutput("idle_leds", leds, 4'h0);
      checkOutput("idle_irq", irqOut, 1'b0);
      readCheck("read_id", 3'd6);
      busWrite(3'd7, 32'hDEAD_BEEF);
      modelWrite(3'd7, 32'hDEAD_BEEF);
      readCheck("scratch_rb", 3'd7);

      // Simultaneous read and write returns the old value.
      avsAddress = 3'd7;
      avsWriteData = 32'h1234_5678;
      avsRead = 1'b1;
      avsWrite = 1'b1;
      tick(1);
      avsRead = 1'b0;
      avsWrite = 1'b0;
      checkOutput("rw_same_old", avsReadData, 32'hDEAD_BEEF);
      modelWrite(3'd7, 32'h1234_5678);
      readCheck("rw_same_new", 3'd7);

      // LED write is visible on the write edge.
      busWrite(3'd0, 32'h5);
      modelWrite(3'd0, 32'h5);
      checkOutput("led_drive", leds, 4'h5);
      readCheck("led_read", 3'd0);

      // Switch acceptance and glitch rejection.
      applyStimulus(4'h3, 4'h0, 1100);
      readCheck("sw_level", 3'd1);
      readCheck("sw_edge", 3'd5);
      applyGlitch(4'hC, 4'h0, 500);
      readCheck("sw_glitch_level", 3'd1);
      readCheck("sw_glitch_edge", 3'd5);
      busWrite(3'd5, 32'h3);
      modelWrite(3'd5, 32'h3);
      readCheck("sw_edge_clr", 3'd5);

      // Button capture drives irq through the mask; clear drops it a cycle later.
      busWrite(3'd3, 32'h1);
      modelWrite(3'd3, 32'h1);
      applyStimulus(4'h3, 4'h1, 1100);
      readCheck("btn_level", 3'd2);
      readCheck("btn_edge", 3'd4);
      checkOutput("btn_irq_set", irqOut, 1'b1);
      busWrite(3'd4, 32'h1);
      modelWrite(3'd4, 32'h1);
      checkOutput("btn_irq_hold", irqOut, 1'b1);
      tick(1);
      checkOutput("btn_irq_clr", irqOut, 1'b0);

      // Randomised input episodes followed by random bus traffic.
      for (int ep = 0; ep < 16; ep++) begin
         kind = int'($urandom_range(0, 2));
         nSw  = 4'($urandom);
         nBtn = 4'($urandom);
         if (kind != 2) applyStimulus(nSw, nBtn, 1100);
         else applyGlitch(nSw, nBtn, int'($urandom_range(1, 900)));
         for (int k = 0; k < 6; k++) begin
            addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
               data = $urandom;
               busWrite(addr, data);
               modelWrite(addr, data);
               checkOutput("rnd_leds", leds, mLed);
            end else begin
               busRead(addr, rd);
               checkOutput("rnd_read", rd, modelRead(addr));
            end
            tick(1);
            checkOutput("rnd_irq", irqOut, modelIrq());
         end
      end

      // Mid-operation reset with LEDs lit and an unmasked capture pending.
      applyStimulus(4'h0, 4'hF, 1100);
      applyStimulus(4'h0, 4'h0, 1100);
      busWrite(3'd0, 32'hF);
      modelWrite(3'd0, 32'hF);
      busWrite(3'd3, 32'hF);
      modelWrite(3'd3, 32'hF);
      tick(1);
      checkOutput("pre_rst_irq", irqOut, 1'b1);
      checkOutput("pre_rst_leds", leds, 4'hF);
      systemReset = 1'b1;
      tick(1);
      systemReset = 1'b0;
      modelReset();
      checkOutput("mid_rst_leds", leds, 4'h0);
      checkOutput("mid_rst_irq", irqOut, 1'b0);
      checkOutput("mid_rst_resetn", resetN, 1'b0);

      // Bus is inert while the fabric reset is held.
      busWrite(3'd0, 32'hA);
      checkOutput("held_wr_ignored", leds, 4'h0);
      busRead(3'd6, rd);
      checkOutput("held_rd_zero", rd, 32'h0);
      waitRelease(cyc);
      checkOutput("re_release", resetN, 1'b1);
      readCheck("post_rst_mask", 3'd3);
      readCheck("post_rst_btnedge", 3'd4);
      readCheck("post_rst_scratch", 3'd7);
      readCheck("post_rst_led", 3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
